// File: rtl/mu_pool_pkg.sv
// ============================================================================
// Module : mu_pool_pkg
// Brief  : Shared FSM state type and accumulator sizing for mu_pool_aggregator
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mu_pool_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Worst case: every channel at full count times full weight.
    function automatic int acc_width(input int cnt_w, input int weight_w, input int num_mu);
        return cnt_w + weight_w + $clog2(num_mu);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mu_pool_aggregator_if.sv
// ============================================================================
// Module : mu_pool_aggregator_if
// Brief  : Spike, config, snapshot-read and result bundle of the MU pool
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mu_pool_aggregator_if #(
    parameter int NUM_MU   = 8,
    parameter int CNT_W    = 32,
    parameter int WEIGHT_W = 16
);
    import mu_pool_pkg::*;

    localparam int AW    = $clog2(NUM_MU);
    localparam int ACC_W = acc_width(CNT_W, WEIGHT_W, NUM_MU);

    logic [NUM_MU-1:0]   spike;
    logic                window_tick;
    logic                cfg_we;
    logic [AW-1:0]       cfg_addr;
    logic [WEIGHT_W-1:0] cfg_wdata;
    logic [AW-1:0]       rd_addr;
    logic [CNT_W-1:0]    rd_data;
    logic [ACC_W-1:0]    total_out;
    logic                total_valid;
    logic                busy;
    logic                overrun;
    logic                sat;

    modport master (
        output spike, window_tick, cfg_we, cfg_addr, cfg_wdata, rd_addr,
        input  rd_data, total_out, total_valid, busy, overrun, sat
    );

    modport slave (
        input  spike, window_tick, cfg_we, cfg_addr, cfg_wdata, rd_addr,
        output rd_data, total_out, total_valid, busy, overrun, sat
    );

endinterface

`default_nettype wire

// File: rtl/mu_spike_counter.sv
// ============================================================================
// Module : mu_spike_counter
// Brief  : Per-channel live spike counter with window snapshot register;
//          saturates instead of wrapping when MU_POOL_SAT_EN is defined
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mu_spike_counter
    import mu_pool_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             i_spike,
    input  wire logic             i_snap,
    output logic [CNT_W-1:0]      o_snapshot,
    output logic                  o_sat_hit
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic [CNT_W-1:0] live_q, live_d;
    logic [CNT_W-1:0] snap_q, snap_d;

    always_comb begin
        live_d    = live_q;
        snap_d    = snap_q;
        o_sat_hit = 1'b0;
        // A spike coincident with the snapshot opens the new window.
        if (i_snap) begin
            snap_d = live_q;
            live_d = i_spike ? c_one : '0;
        end else if (i_spike) begin
`ifdef MU_POOL_SAT_EN
            if (&live_q) begin
                o_sat_hit = 1'b1;
            end else begin
                live_d = live_q + c_one;
            end
`else
            live_d = live_q + c_one;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            live_q <= '0;
            snap_q <= '0;
        end else begin
            live_q <= live_d;
            snap_q <= snap_d;
        end
    end

    assign o_snapshot = snap_q;

endmodule

`default_nettype wire

// File: rtl/mu_pool_aggregator.sv
// ============================================================================
// Module : mu_pool_aggregator
// Brief  : Windowed motor-unit spike counting with serial weighted summation;
//          optional counter saturation under macro MU_POOL_SAT_EN
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mu_pool_aggregator
    import mu_pool_pkg::*;
#(
    parameter int NUM_MU   = 8,
    parameter int CNT_W    = 32,
    parameter int WEIGHT_W = 16
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    mu_pool_aggregator_if.slave     bus
);

    localparam int AW     = $clog2(NUM_MU);
    localparam int ACC_W  = acc_width(CNT_W, WEIGHT_W, NUM_MU);
    localparam int PROD_W = CNT_W + WEIGHT_W;

    localparam logic [AW-1:0]       c_last_idx   = AW'(NUM_MU - 1);
    localparam logic [AW-1:0]       c_idx_one    = AW'(1);
    localparam logic [WEIGHT_W-1:0] c_weight_one = WEIGHT_W'(1);

    state_e              state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    total_q, total_d;
    logic                total_valid_q, total_valid_d;
    logic                overrun_q, overrun_d;
    logic                sat_q, sat_d;
    logic [WEIGHT_W-1:0] weight_q [NUM_MU];
    logic [WEIGHT_W-1:0] weight_d [NUM_MU];

    logic [CNT_W-1:0]    w_snapshot [NUM_MU];
    logic [NUM_MU-1:0]   w_sat_hit;
    logic                w_accept;
    logic [PROD_W-1:0]   w_prod;
    logic [ACC_W-1:0]    w_sum;

    assign w_accept = bus.window_tick && (state_q == IDLE);

    generate
        for (genvar i = 0; i < NUM_MU; i++) begin : g_ch
            mu_spike_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk        (clk),
                .reset_n    (reset_n),
                .i_spike    (bus.spike[i]),
                .i_snap     (w_accept),
                .o_snapshot (w_snapshot[i]),
                .o_sat_hit  (w_sat_hit[i])
            );
        end
    endgenerate

    assign w_prod = PROD_W'(w_snapshot[idx_q]) * PROD_W'(weight_q[idx_q]);
    assign w_sum  = acc_q + ACC_W'(w_prod);

    // Weight RAM is read live during SUM, so a write lands on any later channel cycle.
    always_comb begin
        for (int i = 0; i < NUM_MU; i++) begin
            weight_d[i] = weight_q[i];
        end
        if (bus.cfg_we && (int'(bus.cfg_addr) < NUM_MU)) begin
            weight_d[bus.cfg_addr] = bus.cfg_wdata;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        acc_d         = acc_q;
        total_d       = total_q;
        total_valid_d = 1'b0;
        overrun_d     = overrun_q;
        sat_d         = sat_q | (|w_sat_hit);

        if (bus.window_tick && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.window_tick) begin
                    state_d = SUM;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            SUM: begin
                acc_d = w_sum;
                if (idx_q == c_last_idx) begin
                    state_d       = DONE;
                    total_d       = w_sum;
                    total_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + c_idx_one;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            acc_q         <= '0;
            total_q       <= '0;
            total_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
            sat_q         <= 1'b0;
            for (int i = 0; i < NUM_MU; i++) begin
                weight_q[i] <= c_weight_one;
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            acc_q         <= acc_d;
            total_q       <= total_d;
            total_valid_q <= total_valid_d;
            overrun_q     <= overrun_d;
            sat_q         <= sat_d;
            for (int i = 0; i < NUM_MU; i++) begin
                weight_q[i] <= weight_d[i];
            end
        end
    end

    assign bus.rd_data     = (int'(bus.rd_addr) < NUM_MU) ? w_snapshot[bus.rd_addr] : '0;
    assign bus.total_out   = total_q;
    assign bus.total_valid = total_valid_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.overrun     = overrun_q;
    assign bus.sat         = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_mu_pool_aggregator.sv
// ============================================================================
// Module : tb_mu_pool_aggregator
// Brief  : Directed self-checking bench for mu_pool_aggregator (NUM_MU=4, CNT_W=4)
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mu_pool_aggregator;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    mu_pool_aggregator_if #(.NUM_MU(4), .CNT_W(4), .WEIGHT_W(16)) bus ();

    mu_pool_aggregator #(
        .NUM_MU   (4),
        .CNT_W    (4),
        .WEIGHT_W (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present inputs for one cycle starting at a falling edge, end on the next falling edge.
    task automatic cyc(input logic [3:0] sp, input logic tk);
        bus.spike       = sp;
        bus.window_tick = tk;
        @(negedge clk);
        bus.spike       = '0;
        bus.window_tick = 1'b0;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [15:0] data);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = data;
        @(negedge clk);
        bus.cfg_we    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        bus.rd_addr = addr;
        #1;
        chk(tag, 32'(bus.rd_data), exp);
    endtask

    task automatic count_pulses(input int ncyc, output int pulses);
        pulses = 0;
        for (int i = 0; i < ncyc; i++) begin
            cyc(4'b0000, 1'b0);
            if (bus.total_valid) pulses++;
        end
    endtask

    int pulses;

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        reset_n         = 1'b0;
        bus.spike       = '0;
        bus.window_tick = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_addr    = '0;
        bus.cfg_wdata   = '0;
        bus.rd_addr     = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_total",   32'(bus.total_out), 0);
        chk("rst_valid",   32'(bus.total_valid), 0);
        chk("rst_busy",    32'(bus.busy), 0);
        chk("rst_overrun", 32'(bus.overrun), 0);
        chk("rst_sat",     32'(bus.sat), 0);
        rd("rst_rd0", 2'd0, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // 3,5,0,7 spikes with unit weights -> 15 at T+5
        for (int i = 0; i < 7; i++) begin
            cyc({(i < 7), 1'b0, (i < 5), (i < 3)}, 1'b0);
        end
        cyc(4'b0000, 1'b1);
        chk("s1_busy_t1", 32'(bus.busy), 1);
        repeat (3) cyc(4'b0000, 1'b0);
        chk("s1_valid_t4", 32'(bus.total_valid), 0);
        cyc(4'b0000, 1'b0);
        chk("s1_valid_t5", 32'(bus.total_valid), 1);
        chk("s1_total",    32'(bus.total_out), 15);
        chk("s1_busy_t5",  32'(bus.busy), 1);
        cyc(4'b0000, 1'b0);
        chk("s1_valid_t6", 32'(bus.total_valid), 0);
        chk("s1_busy_t6",  32'(bus.busy), 0);
        rd("s1_rd1", 2'd1, 5);
        rd("s1_rd3", 2'd3, 7);

        // Weights 1,2,4,8 and one spike each -> 15
        wr(2'd0, 16'd1);
        wr(2'd1, 16'd2);
        wr(2'd2, 16'd4);
        wr(2'd3, 16'd8);
        cyc(4'b1111, 1'b0);
        cyc(4'b0000, 1'b1);
        repeat (4) cyc(4'b0000, 1'b0);
        chk("s2_valid", 32'(bus.total_valid), 1);
        chk("s2_total", 32'(bus.total_out), 15);
        cyc(4'b0000, 1'b0);

        // Channel-2 spike on the tick belongs to the following window
        cyc(4'b0100, 1'b1);
        repeat (4) cyc(4'b0000, 1'b0);
        chk("s3_valid_a", 32'(bus.total_valid), 1);
        chk("s3_total_a", 32'(bus.total_out), 0);
        cyc(4'b0000, 1'b0);
        cyc(4'b0000, 1'b1);
        repeat (4) cyc(4'b0000, 1'b0);
        chk("s3_valid_b", 32'(bus.total_valid), 1);
        chk("s3_total_b", 32'(bus.total_out), 4);
        rd("s3_rd2", 2'd2, 1);
        cyc(4'b0000, 1'b0);

        // Second tick two cycles after the first is dropped
        cyc(4'b0001, 1'b0);
        cyc(4'b0000, 1'b1);
        cyc(4'b0000, 1'b0);
        chk("s4_overrun_pre", 32'(bus.overrun), 0);
        cyc(4'b0000, 1'b1);
        chk("s4_overrun", 32'(bus.overrun), 1);
        cyc(4'b0000, 1'b0);
        chk("s4_valid_t4", 32'(bus.total_valid), 0);
        cyc(4'b0000, 1'b0);
        chk("s4_valid_t5", 32'(bus.total_valid), 1);
        chk("s4_total",    32'(bus.total_out), 1);
        count_pulses(10, pulses);
        chk("s4_extra_pulses", 32'(pulses), 0);
        chk("s4_overrun_sticky", 32'(bus.overrun), 1);
        rd("s4_rd0", 2'd0, 1);

        // 20 spikes on channel 0 with a 4-bit counter
        repeat (20) cyc(4'b0001, 1'b0);
`ifdef MU_POOL_SAT_EN
        chk("s5_sat", 32'(bus.sat), 1);
        cyc(4'b0000, 1'b1);
        rd("s5_snap0", 2'd0, 15);
`else
        chk("s5_sat", 32'(bus.sat), 0);
        cyc(4'b0000, 1'b1);
        rd("s5_snap0", 2'd0, 4);
`endif
        repeat (6) cyc(4'b0000, 1'b0);

        // Reset in the middle of SUM
        cyc(4'b0000, 1'b1);
        cyc(4'b0000, 1'b0);
        chk("s6_busy_pre", 32'(bus.busy), 1);
        reset_n = 1'b0;
        #1;
        chk("s6_total",   32'(bus.total_out), 0);
        chk("s6_valid",   32'(bus.total_valid), 0);
        chk("s6_busy",    32'(bus.busy), 0);
        chk("s6_overrun", 32'(bus.overrun), 0);
        chk("s6_sat",     32'(bus.sat), 0);
        rd("s6_rd0", 2'd0, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        count_pulses(8, pulses);
        chk("s6_no_pulse", 32'(pulses), 0);
        cyc(4'b1111, 1'b0);
        cyc(4'b0000, 1'b1);
        repeat (4) cyc(4'b0000, 1'b0);
        chk("s6_valid_after", 32'(bus.total_valid), 1);
        chk("s6_unit_weights", 32'(bus.total_out), 4);
        cyc(4'b0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
